// File: rtl/pipe_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline and pipe_ctrl.
// master = the controller side, slave = the pipeline/fetch side.
interface pipe_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int MDCNT_W = 8
);
  logic [REG_W-1:0]   id_rs1_i;
  logic [REG_W-1:0]   id_rs2_i;
  logic               id_rs1_rd_i;
  logic               id_rs2_rd_i;
  logic [REG_W-1:0]   ex_rd_i;
  logic               ex_is_load_i;
  logic               ex_jump_i;
  logic [ADDR_W-1:0]  ex_jump_addr_i;
  logic               ex_md_start_i;
  logic               md_done_i;
  logic               imem_ready_i;

  logic [3:0]         stall_o;
  logic               if_id_flush_o;
  logic               id_ex_flush_o;
  logic               ex_mem_flush_o;
  logic               pc_redirect_o;
  logic [ADDR_W-1:0]  pc_redirect_addr_o;
  logic [MDCNT_W-1:0] md_cycles_o;

  modport master (
    input  id_rs1_i, id_rs2_i, id_rs1_rd_i, id_rs2_rd_i,
    input  ex_rd_i, ex_is_load_i, ex_jump_i, ex_jump_addr_i,
    input  ex_md_start_i, md_done_i, imem_ready_i,
    output stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
    output pc_redirect_o, pc_redirect_addr_o, md_cycles_o
  );

  modport slave (
    output id_rs1_i, id_rs2_i, id_rs1_rd_i, id_rs2_rd_i,
    output ex_rd_i, ex_is_load_i, ex_jump_i, ex_jump_addr_i,
    output ex_md_start_i, md_done_i, imem_ready_i,
    input  stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
    input  pc_redirect_o, pc_redirect_addr_o, md_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-cycle hold/flush of PC, IF/ID, ID/EX, EX/MEM
// and PC redirects; outputs are Mealy (same-cycle response to the cause).
//
// state      | meaning
// -----------+---------------------------------------------------------------
// RUN        | normal issue; jump > mul/div > load-use > imem wait priority
// MD_WAIT    | mul/div in EX busy; front end held, EX/MEM fed bubbles
// REDIR_PEND | taken jump seen while imem busy; keep redirecting to pend_addr
module pipe_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int MDCNT_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pipe_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MD_WAIT    = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  localparam logic [MDCNT_W-1:0] MD_ONE  = {{(MDCNT_W-1){1'b0}}, 1'b1};
  localparam logic [MDCNT_W-1:0] MD_SAT  = {MDCNT_W{1'b1}};
  localparam logic [REG_W-1:0]   REG_X0  = {REG_W{1'b0}};

  localparam logic [3:0] STALL_NONE = 4'b0000;
  localparam logic [3:0] STALL_PC   = 4'b0001;
  localparam logic [3:0] STALL_LU   = 4'b0011;
  localparam logic [3:0] STALL_MD   = 4'b0111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [MDCNT_W-1:0]  md_cnt_q, md_cnt_d;

  logic                load_use;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                md_begin;

  logic [3:0]          stall_c;
  logic                if_id_flush_c;
  logic                id_ex_flush_c;
  logic                ex_mem_flush_c;
  logic                redirect_c;
  logic [ADDR_W-1:0]   redirect_addr_c;

  always_comb begin
    rs1_hit  = bus.id_rs1_rd_i && (bus.id_rs1_i == bus.ex_rd_i);
    rs2_hit  = bus.id_rs2_rd_i && (bus.id_rs2_i == bus.ex_rd_i);
    load_use = bus.ex_is_load_i && (bus.ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);
    // a mul/div that finishes in its first EX cycle needs no stall at all
    md_begin = bus.ex_md_start_i && !bus.md_done_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      pend_addr_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pend_addr_d     = pend_addr_q;
    md_cnt_d        = md_cnt_q;
    stall_c         = STALL_NONE;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_flush_c  = 1'b0;
    redirect_c      = 1'b0;
    redirect_addr_c = '0;

    case (state_q)
      RUN: begin
        if (bus.ex_jump_i) begin
          redirect_c      = 1'b1;
          redirect_addr_c = bus.ex_jump_addr_i;
          if_id_flush_c   = 1'b1;
          id_ex_flush_c   = 1'b1;
          if (!bus.imem_ready_i) begin
            pend_addr_d = bus.ex_jump_addr_i;
            state_d     = REDIR_PEND;
          end
        end else if (md_begin) begin
          stall_c        = STALL_MD;
          ex_mem_flush_c = 1'b1;
          md_cnt_d       = MD_ONE;
          state_d        = MD_WAIT;
        end else if (load_use) begin
          stall_c       = STALL_LU;
          id_ex_flush_c = 1'b1;
        end else if (!bus.imem_ready_i) begin
          stall_c       = STALL_PC;
          if_id_flush_c = 1'b1;
        end
      end

      MD_WAIT: begin
        if (!bus.md_done_i) begin
          stall_c        = STALL_MD;
          ex_mem_flush_c = 1'b1;
          if (md_cnt_q != MD_SAT) begin
            md_cnt_d = md_cnt_q + MD_ONE;
          end
        end else begin
          state_d = RUN;
        end
      end

      REDIR_PEND: begin
        redirect_c    = 1'b1;
        if_id_flush_c = 1'b1;
        // EX should hold a bubble here; a late jump still takes over the target
        if (bus.ex_jump_i) begin
          pend_addr_d     = bus.ex_jump_addr_i;
          redirect_addr_c = bus.ex_jump_addr_i;
        end else begin
          redirect_addr_c = pend_addr_q;
        end
        if (bus.imem_ready_i) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // outputs are forced quiet for the whole time reset is held
  always_comb begin
    if (rst_i) begin
      bus.stall_o            = STALL_NONE;
      bus.if_id_flush_o      = 1'b0;
      bus.id_ex_flush_o      = 1'b0;
      bus.ex_mem_flush_o     = 1'b0;
      bus.pc_redirect_o      = 1'b0;
      bus.pc_redirect_addr_o = '0;
      bus.md_cycles_o        = '0;
    end else begin
      bus.stall_o            = stall_c;
      bus.if_id_flush_o      = if_id_flush_c;
      bus.id_ex_flush_o      = id_ex_flush_c;
      bus.ex_mem_flush_o     = ex_mem_flush_c;
      bus.pc_redirect_o      = redirect_c;
      bus.pc_redirect_addr_o = redirect_addr_c;
      bus.md_cycles_o        = md_cnt_q;
    end
  end

endmodule
